// File: rtl/nandgame_pkg.sv
// nandgame_pkg
// Shared definitions for the nandgame core: instruction field bit positions,
// indices into the 3-bit destination enable vector, and the ALU operation
// encoding formed by concatenating the u and op instruction fields.
package nandgame_pkg;

  // Instruction field bit positions
  localparam int CI      = 15;  // 0 = immediate load into A, 1 = ALU instruction
  localparam int SM      = 12;  // Y source: 0 = A, 1 = *A
  localparam int U       = 10;  // 0 = logic unit, 1 = arithmetic unit
  localparam int OP_HI   = 9;
  localparam int OP_LO   = 8;
  localparam int ZX      = 7;   // zero X (applied after the swap)
  localparam int SW      = 6;   // swap X and Y
  localparam int DEST_HI = 5;   // destination field, ordered {A, D, *A}
  localparam int DEST_LO = 3;
  localparam int JMP_LT  = 2;
  localparam int JMP_EQ  = 1;
  localparam int JMP_GT  = 0;

  // Bit indices of the destination enable vector
  localparam int W_MEM = 0;
  localparam int W_D   = 1;
  localparam int W_A   = 2;

  // {u, op} selects one of eight ALU functions
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_ADD = 3'b100,
    OP_INC = 3'b101,
    OP_SUB = 3'b110,
    OP_DEC = 3'b111
  } alu_op_t;

endpackage

// File: rtl/control_unit_alu.sv
// alu
// Purely combinational nandgame ALU. The operands are optionally swapped,
// then the (new) X operand is optionally zeroed, then one of four logic or
// four arithmetic functions is applied. Arithmetic wraps modulo 2^16.
//
// Ports:
//   op_x   in  16  X operand (D in the core)
//   op_y   in  16  Y operand (A or *A in the core)
//   u      in  1   0 = logic unit, 1 = arithmetic unit
//   op     in  2   function select within the unit
//   zx     in  1   zero X after the swap
//   sw     in  1   swap X and Y
//   result out 16  function result
module alu
  import nandgame_pkg::*;
(
  input  logic [15:0] op_x,
  input  logic [15:0] op_y,
  input  logic        u,
  input  logic [1:0]  op,
  input  logic        zx,
  input  logic        sw,
  output logic [15:0] result
);

  logic [15:0] x_eff;
  logic [15:0] y_eff;
  alu_op_t     sel;

  always_comb begin
    x_eff  = sw ? op_y : op_x;
    y_eff  = sw ? op_x : op_y;
    sel    = alu_op_t'({u, op});
    result = '0;
    // Zeroing applies to the post-swap X, so zx with sw zeroes the original Y.
    if (zx) begin
      x_eff = '0;
    end
    case (sel)
      OP_AND:  result = x_eff & y_eff;
      OP_OR:   result = x_eff | y_eff;
      OP_XOR:  result = x_eff ^ y_eff;
      OP_NOT:  result = ~x_eff;
      OP_ADD:  result = x_eff + y_eff;
      OP_INC:  result = x_eff + 16'd1;
      OP_SUB:  result = x_eff - y_eff;
      OP_DEC:  result = x_eff - 16'd1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Pipelined fetch/decode/execute sequencer for the nandgame core. Fetches one
// instruction per cycle from a synchronous ROM, computes the ALU result from
// D, A and *A, drives the value and destination enables to the memory block,
// and resolves jumps. A taken jump inserts one bubble. Reading *A right after
// a write to A or *A inserts one stall, because the memory block's *A output
// needs one extra edge to reflect the new address/contents.
//
// Ports:
//   clk        in  1         rising-edge clock
//   rst        in  1         asynchronous active-high reset
//   instr_addr out PC_WIDTH  ROM address (data returns one cycle later)
//   instr_data in  16        instruction word from the ROM
//   a_reg      in  16        current A
//   d_reg      in  16        current D
//   a_mem_reg  in  16        current *A
//   x          out 16        ALU result or immediate, committed by memory
//   write      out 3         destination enables {A, D, *A}
//   stall      out 1         high during a hazard-stall cycle
//   retired    out 1         pulses once per executed instruction
module control_unit
  import nandgame_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic [15:0]         instr_data,
  input  logic [15:0]         a_reg,
  input  logic [15:0]         d_reg,
  input  logic [15:0]         a_mem_reg,
  output logic [15:0]         x,
  output logic [2:0]          write,
  output logic                stall,
  output logic                retired
);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic                ex_valid;
  logic                prev_am;

  logic                is_alu;
  logic [15:0]         y_sel;
  logic [15:0]         alu_result;
  logic [2:0]          dest;
  logic                negative;
  logic                zero;
  logic                jump;
  logic                hazard;
  logic                unused_bits;

  assign is_alu      = instr_data[CI];
  assign y_sel       = instr_data[SM] ? a_mem_reg : a_reg;
  assign unused_bits = ^{instr_data[14:13], instr_data[11]};

  alu u_alu (
    .op_x   (d_reg),
    .op_y   (y_sel),
    .u      (instr_data[U]),
    .op     (instr_data[OP_HI:OP_LO]),
    .zx     (instr_data[ZX]),
    .sw     (instr_data[SW]),
    .result (alu_result)
  );

  // Decode, jump condition and hazard detection. Everything here is gated by
  // ex_valid, so an asynchronous reset drops write/retired/stall at once.
  always_comb begin
    x        = is_alu ? alu_result : instr_data;
    dest     = is_alu ? instr_data[DEST_HI:DEST_LO] : 3'b100;
    negative = x[15];
    zero     = (x == 16'd0);
    jump     = is_alu & ((instr_data[JMP_LT] & negative) |
                         (instr_data[JMP_EQ] & zero) |
                         (instr_data[JMP_GT] & ~negative & ~zero));
    hazard   = ex_valid & is_alu & instr_data[SM] & prev_am;
    stall    = hazard;
    retired  = ex_valid & ~hazard;
    write    = retired ? dest : 3'b000;
    // fetch_pc always points one past the word currently in instr_data. While
    // stalled, the ROM is re-addressed with the current word's own address so
    // that the same instruction comes back next cycle; fetch_pc itself holds.
    instr_addr = hazard ? (fetch_pc - PC_WIDTH'(1)) : fetch_pc;
  end

  // Fetch pointer and pipeline bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= '0;
      ex_valid <= 1'b0;
      prev_am  <= 1'b0;
    end else if (!ex_valid) begin
      fetch_pc <= fetch_pc + PC_WIDTH'(1);
      ex_valid <= 1'b1;
      prev_am  <= 1'b0;
    end else if (hazard) begin
      prev_am  <= 1'b0;
    end else begin
      prev_am <= dest[W_A] | dest[W_MEM];
      if (jump) begin
        // Target is the A value before this instruction's own write lands;
        // the word already in flight from the ROM is discarded.
        fetch_pc <= a_reg[PC_WIDTH-1:0];
        ex_valid <= 1'b0;
      end else begin
        fetch_pc <= fetch_pc + PC_WIDTH'(1);
      end
    end
  end

endmodule
